fifo_ext: RTL and testbench

//  Parameterised successor to the UART byte FIFO: circular buffer of any depth >= 2 (including non-power-of-2).

---
 rtl/fifo_ext.sv | 135 +++++++++++++
 tb/tb_fifo_ext.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ext.sv
// rtl/fifo_ext.sv - parameterised circular FIFO with thresholds, fill level, peak watermark and sticky error flags
module fifo_ext #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_AFULL_LVL  = 14,
    parameter int P_AEMPTY_LVL = 2,
    localparam int CW = $clog2(P_FIFO_DEPTH + 1)
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iFlush,
    input  logic                    iClrErr,
    input  logic                    iPush,
    input  logic [P_DATA_WIDTH-1:0] iPushData,
    input  logic                    iPop,
    output logic [P_DATA_WIDTH-1:0] oPopData,
    output logic                    oFull,
    output logic                    oEmpty,
    output logic                    oAlmostFull,
    output logic                    oAlmostEmpty,
    output logic [CW-1:0]           oLevel,
    output logic [CW-1:0]           oPeak,
    output logic                    oOverflow,
    output logic                    oUnderflow
);

    localparam int PW = $clog2(P_FIFO_DEPTH);
    localparam logic [CW-1:0] LVL_FULL   = CW'(P_FIFO_DEPTH);
    localparam logic [CW-1:0] LVL_AFULL  = CW'(P_AFULL_LVL);
    localparam logic [CW-1:0] LVL_AEMPTY = CW'(P_AEMPTY_LVL);
    localparam logic [PW-1:0] PTR_LAST   = PW'(P_FIFO_DEPTH - 1);

    if (P_FIFO_DEPTH < 2 || P_AFULL_LVL < 1 || P_AFULL_LVL > P_FIFO_DEPTH ||
        P_AEMPTY_LVL < 0 || P_AEMPTY_LVL > P_FIFO_DEPTH - 1) begin : g_bad_params
        $error("fifo_ext: illegal parameter set");
    end

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_FLUSH,
        OP_PUSH_ONLY,
        OP_POP_ONLY,
        OP_PUSH_POP
    } op_t;

    logic [P_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [CW-1:0] level, level_nxt, peak, peak_nxt;
    logic          ovf, udf;
    logic          push_acc, pop_acc, ovf_set, udf_set;
    op_t           op;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign oFull        = (level == LVL_FULL);
    assign oEmpty       = (level == '0);
    assign oAlmostFull  = (level >= LVL_AFULL);
    assign oAlmostEmpty = (level <= LVL_AEMPTY);
    assign oLevel       = level;
    assign oPeak        = peak;
    assign oOverflow    = ovf;
    assign oUnderflow   = udf;
    assign oPopData     = mem[rd_ptr];

    assign push_acc = iPush & ~oFull  & ~iFlush;
    assign pop_acc  = iPop  & ~oEmpty & ~iFlush;
    assign ovf_set  = iPush & oFull   & ~iFlush;
    assign udf_set  = iPop  & oEmpty  & ~iFlush;

    always_comb begin
        op = OP_IDLE;
        if (iFlush)                   op = OP_FLUSH;
        else if (push_acc && pop_acc) op = OP_PUSH_POP;
        else if (push_acc)            op = OP_PUSH_ONLY;
        else if (pop_acc)             op = OP_POP_ONLY;
    end

    always_comb begin
        wr_nxt    = wr_ptr;
        rd_nxt    = rd_ptr;
        level_nxt = level;
        case (op)
            OP_FLUSH: begin
                wr_nxt    = '0;
                rd_nxt    = '0;
                level_nxt = '0;
            end
            OP_PUSH_ONLY: begin
                wr_nxt    = ptr_inc(wr_ptr);
                level_nxt = level + 1'b1;
            end
            OP_POP_ONLY: begin
                rd_nxt    = ptr_inc(rd_ptr);
                level_nxt = level - 1'b1;
            end
            OP_PUSH_POP: begin
                wr_nxt = ptr_inc(wr_ptr);
                rd_nxt = ptr_inc(rd_ptr);
            end
            default: ;
        endcase
    end

    // Clearing reloads the watermark with the level being entered, not zero.
    always_comb begin
        peak_nxt = (level_nxt > peak) ? level_nxt : peak;
        if (iClrErr) peak_nxt = level_nxt;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            peak   <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            level  <= level_nxt;
            peak   <= peak_nxt;
            ovf    <= ovf_set | (ovf & ~iClrErr);
            udf    <= udf_set | (udf & ~iClrErr);
        end
    end

    always_ff @(posedge iClk) begin
        if (op == OP_PUSH_ONLY || op == OP_PUSH_POP) mem[wr_ptr] <= iPushData;
    end

endmodule

// File: tb/tb_fifo_ext.sv
// tb/tb_fifo_ext.sv - directed bench for fifo_ext (default and depth-5 instances) against a list model
module tb_fifo_ext;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       flush [2];
    logic       clr   [2];
    logic       push  [2];
    logic [7:0] pdat  [2];
    logic       pop   [2];

    logic [7:0] odat  [2];
    logic       o_full [2], o_empty [2], o_afull [2], o_aempty [2], o_ovf [2], o_udf [2];
    logic [4:0] lvl0, pk0;
    logic [2:0] lvl1, pk1;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    int mdepth [2] = '{16, 5};
    int mafull [2] = '{14, 4};
    int maempt [2] = '{2, 1};
    int mlist  [2][16];
    int mcnt   [2];
    int mpeak  [2];
    bit movf   [2];
    bit mudf   [2];

    always #5 iClk = ~iClk;

    fifo_ext u0 (
        .iClk(iClk), .iRst(iRst), .iFlush(flush[0]), .iClrErr(clr[0]),
        .iPush(push[0]), .iPushData(pdat[0]), .iPop(pop[0]), .oPopData(odat[0]),
        .oFull(o_full[0]), .oEmpty(o_empty[0]), .oAlmostFull(o_afull[0]),
        .oAlmostEmpty(o_aempty[0]), .oLevel(lvl0), .oPeak(pk0),
        .oOverflow(o_ovf[0]), .oUnderflow(o_udf[0])
    );

    fifo_ext #(.P_DATA_WIDTH(8), .P_FIFO_DEPTH(5), .P_AFULL_LVL(4), .P_AEMPTY_LVL(1)) u1 (
        .iClk(iClk), .iRst(iRst), .iFlush(flush[1]), .iClrErr(clr[1]),
        .iPush(push[1]), .iPushData(pdat[1]), .iPop(pop[1]), .oPopData(odat[1]),
        .oFull(o_full[1]), .oEmpty(o_empty[1]), .oAlmostFull(o_afull[1]),
        .oAlmostEmpty(o_aempty[1]), .oLevel(lvl1), .oPeak(pk1),
        .oOverflow(o_ovf[1]), .oUnderflow(o_udf[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an ordered list of stored words; pop removes the front, push appends.
    always @(posedge iClk or posedge iRst) begin
        for (int k = 0; k < 2; k++) begin
            if (iRst) begin
                mcnt[k] = 0; mpeak[k] = 0; movf[k] = 0; mudf[k] = 0;
            end else begin
                bit oset, uset;
                oset = 0; uset = 0;
                if (flush[k]) begin
                    mcnt[k] = 0;
                end else begin
                    bit was_full, was_empty;
                    was_full  = (mcnt[k] == mdepth[k]);
                    was_empty = (mcnt[k] == 0);
                    oset = push[k] && was_full;
                    uset = pop[k] && was_empty;
                    if (pop[k] && !was_empty) begin
                        for (int j = 0; j < 15; j++) mlist[k][j] = mlist[k][j+1];
                        mcnt[k]--;
                    end
                    if (push[k] && !was_full) begin
                        mlist[k][mcnt[k]] = int'(pdat[k]);
                        mcnt[k]++;
                    end
                end
                movf[k] = oset || (movf[k] && !clr[k]);
                mudf[k] = uset || (mudf[k] && !clr[k]);
                if (clr[k])                mpeak[k] = mcnt[k];
                else if (mcnt[k] > mpeak[k]) mpeak[k] = mcnt[k];
            end
        end
    end

    always @(negedge iClk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.level", k), (k == 0) ? int'(lvl0) : int'(lvl1), mcnt[k]);
                chk($sformatf("u%0d.peak", k), (k == 0) ? int'(pk0) : int'(pk1), mpeak[k]);
                chk($sformatf("u%0d.full", k), int'(o_full[k]), int'(mcnt[k] == mdepth[k]));
                chk($sformatf("u%0d.empty", k), int'(o_empty[k]), int'(mcnt[k] == 0));
                chk($sformatf("u%0d.afull", k), int'(o_afull[k]), int'(mcnt[k] >= mafull[k]));
                chk($sformatf("u%0d.aempty", k), int'(o_aempty[k]), int'(mcnt[k] <= maempt[k]));
                chk($sformatf("u%0d.ovf", k), int'(o_ovf[k]), int'(movf[k]));
                chk($sformatf("u%0d.udf", k), int'(o_udf[k]), int'(mudf[k]));
                if (mcnt[k] > 0) chk($sformatf("u%0d.data", k), int'(odat[k]), mlist[k][0]);
            end
        end
    end

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            flush[k] = 0; clr[k] = 0; push[k] = 0; pop[k] = 0; pdat[k] = 8'h00;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge iClk);
    endtask

    initial begin
        idle_all();
        cyc(2);
        chk("rst.level", int'(lvl0), 0);
        chk("rst.empty", int'(o_empty[0]), 1);
        chk("rst.aempty", int'(o_aempty[0]), 1);
        chk("rst.afull", int'(o_afull[0]), 0);
        chk("rst.full", int'(o_full[0]), 0);
        iRst   = 0;
        chk_en = 1;

        // T1: fill, overflow, drain in order
        push[0] = 1;
        for (int i = 0; i < 16; i++) begin
            pdat[0] = 8'(i);
            cyc(1);
            if (i == 12) chk("t1.afull_at13", int'(o_afull[0]), 0);
            if (i == 13) chk("t1.afull_at14", int'(o_afull[0]), 1);
        end
        chk("t1.level16", int'(lvl0), 16);
        chk("t1.full", int'(o_full[0]), 1);
        pdat[0] = 8'hAA;
        cyc(1);
        push[0] = 0;
        chk("t1.ovf", int'(o_ovf[0]), 1);
        chk("t1.level_after_ovf", int'(lvl0), 16);
        pop[0] = 1;
        for (int i = 0; i < 16; i++) begin
            chk("t1.pop_data", int'(odat[0]), i);
            cyc(1);
        end
        pop[0] = 0;
        chk("t1.empty", int'(o_empty[0]), 1);

        // T2: depth 5 wraps
        push[1] = 1;
        for (int i = 1; i <= 3; i++) begin pdat[1] = 8'(i); cyc(1); end
        push[1] = 0; pop[1] = 1; cyc(3); pop[1] = 0;
        push[1] = 1;
        for (int i = 0; i < 5; i++) begin pdat[1] = 8'h10 + 8'(i); cyc(1); end
        push[1] = 0;
        chk("t2.full", int'(o_full[1]), 1);
        chk("t2.level5", int'(lvl1), 5);
        pop[1] = 1;
        for (int i = 0; i < 5; i++) begin
            chk("t2.pop_data", int'(odat[1]), 8'h10 + i);
            cyc(1);
        end
        pop[1] = 0;

        // T3: simultaneous push+pop at empty, mid level and full
        clr[0] = 1; cyc(1); clr[0] = 0;
        push[0] = 1; pop[0] = 1; pdat[0] = 8'h30; cyc(1);
        chk("t3.empty_level1", int'(lvl0), 1);
        chk("t3.udf", int'(o_udf[0]), 1);
        pop[0] = 0;
        for (int i = 1; i < 8; i++) begin pdat[0] = 8'h30 + 8'(i); cyc(1); end
        pop[0] = 1;
        for (int i = 8; i < 12; i++) begin pdat[0] = 8'h30 + 8'(i); cyc(1); end
        chk("t3.level8", int'(lvl0), 8);
        chk("t3.head_after_pp", int'(odat[0]), 8'h34);
        pop[0] = 0;
        for (int i = 12; i < 20; i++) begin pdat[0] = 8'h30 + 8'(i); cyc(1); end
        pop[0] = 1; pdat[0] = 8'hEE; cyc(1);
        chk("t3.full_pp_level15", int'(lvl0), 15);
        chk("t3.full_pp_ovf", int'(o_ovf[0]), 1);
        push[0] = 0; cyc(15); pop[0] = 0;

        // T4: flush at level 10 while pushing
        clr[0] = 1; cyc(1); clr[0] = 0;
        push[0] = 1;
        for (int i = 0; i < 10; i++) begin pdat[0] = 8'h50 + 8'(i); cyc(1); end
        flush[0] = 1; cyc(1); flush[0] = 0; push[0] = 0;
        chk("t4.level0", int'(lvl0), 0);
        chk("t4.empty", int'(o_empty[0]), 1);
        chk("t4.aempty", int'(o_aempty[0]), 1);
        chk("t4.ovf", int'(o_ovf[0]), 0);
        chk("t4.peak10", int'(pk0), 10);

        // T5: clear colliding with overflow, then peak reload
        push[0] = 1;
        for (int i = 0; i < 16; i++) begin pdat[0] = 8'h60 + 8'(i); cyc(1); end
        clr[0] = 1; pdat[0] = 8'hBB; cyc(1); push[0] = 0;
        chk("t5.ovf_wins", int'(o_ovf[0]), 1);
        cyc(1); clr[0] = 0;
        chk("t5.ovf_cleared", int'(o_ovf[0]), 0);
        chk("t5.peak16", int'(pk0), 16);
        pop[0] = 1; cyc(4); pop[0] = 0;
        clr[0] = 1; cyc(1); clr[0] = 0;
        chk("t5.peak_reload12", int'(pk0), 12);

        // T6: asynchronous reset at level 6
        flush[0] = 1; cyc(1); flush[0] = 0;
        push[0] = 1;
        for (int i = 0; i < 6; i++) begin pdat[0] = 8'h70 + 8'(i); cyc(1); end
        chk("t6.level6", int'(lvl0), 6);
        pdat[0] = 8'h7F;
        #2 iRst = 1;
        #1;
        chk("t6.async_level", int'(lvl0), 0);
        chk("t6.async_peak", int'(pk0), 0);
        chk("t6.async_empty", int'(o_empty[0]), 1);
        chk("t6.async_aempty", int'(o_aempty[0]), 1);
        chk("t6.async_afull", int'(o_afull[0]), 0);
        cyc(2);
        iRst = 0; pdat[0] = 8'h5A; cyc(1); push[0] = 0;
        chk("t6.post_level", int'(lvl0), 1);
        chk("t6.post_data", int'(odat[0]), 8'h5A);
        cyc(2);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
